// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared core types: privilege constants, fetch FSM states, fetch-queue entry
package fetch_unit_pkg;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT_SPACE,
        ST_DRAIN,
        ST_FAULT
    } fetch_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        page_fault;
    } fq_entry_t;

    function automatic logic [63:0] align_pc(input logic [63:0] pc);
        return pc & ~64'h3;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - I$ request/response, redirect and decode-side handshake bundle
interface fetch_unit_if;
    logic        ic_en;
    logic [63:0] ic_req_addr;
    logic        ic_resp_valid;
    logic        ic_resp_page_fault;
    logic [31:0] ic_resp_inst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_page_fault;

    modport master (
        output ic_en, ic_req_addr, out_valid, out_pc, out_inst, out_page_fault,
        input  ic_resp_valid, ic_resp_page_fault, ic_resp_inst,
               redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  ic_en, ic_req_addr, out_valid, out_pc, out_inst, out_page_fault,
        output ic_resp_valid, ic_resp_page_fault, ic_resp_inst,
               redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - power-of-two circular fetch queue with flush; head driven straight from storage
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  fq_entry_t     push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [CW-1:0] count_o,
    output logic          head_valid_o,
    output fq_entry_t     head_o
);

    fq_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   rd_q, wr_q;
    logic [CW-1:0]   count_q;
    logic            do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0) && !flush_i;
    assign do_push = push_i && ((count_q < CW'(DEPTH)) || do_pop) && !flush_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Payload needs no reset: it is only visible while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != '0);
    assign head_o       = head_valid_o ? mem_q[rd_q] : '0;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding I$ fetcher with redirect/drain handling feeding a fetch queue
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          FQ_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    logic [63:0]   tgt_q, tgt_d;
    logic          push, pop, head_valid;
    fq_entry_t     push_entry, head;
    logic [CW-1:0] count;
    logic [CW:0]   occ_after;
    logic [63:0]   redirect_tgt;

    fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (bus.redirect_valid),
        .count_o     (count),
        .head_valid_o(head_valid),
        .head_o      (head)
    );

    assign pop          = head_valid && bus.out_ready;
    assign redirect_tgt = align_pc(bus.redirect_pc);
    // Occupancy after this cycle's push/pop; the next request needs it below FQ_DEPTH.
    assign occ_after    = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            tgt_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        push       = 1'b0;
        push_entry = '0;
        unique case (state_q)
            ST_FETCH: begin
                if (bus.redirect_valid) begin
                    if (bus.ic_resp_valid) begin
                        pc_d = redirect_tgt;
                    end else begin
                        state_d = ST_DRAIN;
                        tgt_d   = redirect_tgt;
                    end
                end else if (bus.ic_resp_valid) begin
                    push          = 1'b1;
                    push_entry.pc = pc_q;
                    if (bus.ic_resp_page_fault) begin
                        push_entry.page_fault = 1'b1;
                        state_d               = ST_FAULT;
                    end else begin
                        push_entry.inst = bus.ic_resp_inst;
                        pc_d            = pc_q + 64'd4;
                        state_d = (occ_after < (CW+1)'(FQ_DEPTH)) ? ST_FETCH : ST_WAIT_SPACE;
                    end
                end
            end
            ST_WAIT_SPACE: begin
                if (bus.redirect_valid) begin
                    state_d = ST_FETCH;
                    pc_d    = redirect_tgt;
                end else if (pop) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (bus.ic_resp_valid) begin
                    state_d = ST_FETCH;
                    pc_d    = bus.redirect_valid ? redirect_tgt : tgt_q;
                end else if (bus.redirect_valid) begin
                    tgt_d = redirect_tgt;
                end
            end
            ST_FAULT: begin
                if (bus.redirect_valid) begin
                    state_d = ST_FETCH;
                    pc_d    = redirect_tgt;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign bus.ic_en          = !reset && ((state_q == ST_FETCH) || (state_q == ST_DRAIN));
    assign bus.ic_req_addr    = pc_q;
    assign bus.out_valid      = head_valid;
    assign bus.out_pc         = head.pc;
    assign bus.out_inst       = head.page_fault ? 32'h0 : head.inst;
    assign bus.out_page_fault = head.page_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a latency-randomised I$ responder
module tb_fetch_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(64'h0), .FQ_DEPTH(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    int          checks = 0;
    int          failures = 0;
    int          lat_min = 2;
    int          lat_max = 2;
    logic        fault_en = 1'b0;
    logic [63:0] fault_addr = 64'h0;
    int          resp_count = 0;
    int          cnt = 0;
    int          cur_lat = 2;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    // Memory side: answers the current request after cur_lat cycles of ic_en.
    always @(negedge clk) begin
        if (reset) begin
            cnt = 0;
            bus.ic_resp_valid      = 1'b0;
            bus.ic_resp_page_fault = 1'b0;
            bus.ic_resp_inst       = 32'h0;
        end else begin
            bus.ic_resp_valid      = 1'b0;
            bus.ic_resp_page_fault = 1'b0;
            bus.ic_resp_inst       = 32'h0;
            if (bus.ic_en) begin
                if (cnt == 0) cur_lat = $urandom_range(lat_max, lat_min);
                cnt++;
                if (cnt >= cur_lat) begin
                    bus.ic_resp_valid      = 1'b1;
                    bus.ic_resp_inst       = inst_of(bus.ic_req_addr);
                    bus.ic_resp_page_fault = fault_en && (bus.ic_req_addr == fault_addr);
                    resp_count++;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        bus.out_ready      = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        lat_min = 2; lat_max = 2;
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        bus.out_ready      = 1'b1;
        repeat (3) tick();
        checks++; if (bus.ic_en !== 1'b0) begin failures++; $display("FAIL reset_ic_en: got %b want 0", bus.ic_en); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_pc !== 64'h0 || bus.out_inst !== 32'h0 || bus.out_page_fault !== 1'b0) begin
            failures++; $display("FAIL reset_out_fields: got pc=%h inst=%h pf=%b want zeros", bus.out_pc, bus.out_inst, bus.out_page_fault);
        end
        reset = 1'b0;
        tick();
        checks++; if (bus.ic_en !== 1'b1 || bus.ic_req_addr !== 64'h0) begin
            failures++; $display("FAIL reset_first_req: got en=%b addr=%h want en=1 addr=0", bus.ic_en, bus.ic_req_addr);
        end
    endtask

    task automatic test_sequence();
        logic [63:0] exp_pc = 64'h0;
        int n = 0;
        lat_min = 2; lat_max = 2;
        do_reset();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 200 && n < 4; c++) begin
            tick();
            if (bus.out_valid) begin
                checks++;
                if (bus.out_pc !== exp_pc || bus.out_inst !== inst_of(exp_pc) || bus.out_page_fault !== 1'b0) begin
                    failures++; $display("FAIL seq_entry%0d: got pc=%h inst=%h pf=%b want pc=%h inst=%h pf=0",
                                         n, bus.out_pc, bus.out_inst, bus.out_page_fault, exp_pc, inst_of(exp_pc));
                end
                exp_pc += 64'd4;
                n++;
            end
        end
        checks++; if (n != 4) begin failures++; $display("FAIL seq_count: got %0d entries want 4", n); end
    endtask

    task automatic test_backpressure();
        int base;
        lat_min = 2; lat_max = 2;
        do_reset();
        base = resp_count;
        repeat (40) tick();
        checks++; if (resp_count - base != 4) begin failures++; $display("FAIL bp_requests: got %0d want 4", resp_count - base); end
        checks++; if (bus.ic_en !== 1'b0 || bus.ic_req_addr !== 64'h10) begin
            failures++; $display("FAIL bp_stalled: got en=%b addr=%h want en=0 addr=10", bus.ic_en, bus.ic_req_addr);
        end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0) begin
            failures++; $display("FAIL bp_head: got valid=%b pc=%h want 1/0", bus.out_valid, bus.out_pc);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.ic_en !== 1'b1 || bus.ic_req_addr !== 64'h10 || bus.out_pc !== 64'h4) begin
            failures++; $display("FAIL bp_resume: got en=%b addr=%h head=%h want en=1 addr=10 head=4", bus.ic_en, bus.ic_req_addr, bus.out_pc);
        end
        repeat (10) tick();
        checks++; if (resp_count - base != 5 || bus.ic_en !== 1'b0) begin
            failures++; $display("FAIL bp_refill: got reqs=%0d en=%b want 5/0", resp_count - base, bus.ic_en);
        end
    endtask

    task automatic test_redirect_drain();
        int seen_bad = 0;
        bit moved = 0;
        lat_min = 3; lat_max = 3;
        do_reset();
        bus.out_ready = 1'b1;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_1002;
        tick();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.ic_en !== 1'b1 || bus.ic_req_addr !== 64'h0) begin
            failures++; $display("FAIL drain_hold: got en=%b addr=%h want en=1 addr=0", bus.ic_en, bus.ic_req_addr);
        end
        for (int c = 0; c < 10 && !moved; c++) begin
            tick();
            if (bus.out_valid) seen_bad++;
            if (bus.ic_req_addr != 64'h0) moved = 1;
        end
        checks++; if (!moved || bus.ic_req_addr !== 64'h8000_1000) begin
            failures++; $display("FAIL drain_target: got addr=%h want 80001000", bus.ic_req_addr);
        end
        checks++; if (seen_bad != 0) begin failures++; $display("FAIL drain_stale: got %0d stale entries want 0", seen_bad); end
        for (int c = 0; c < 20 && !bus.out_valid; c++) tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h8000_1000 || bus.out_inst !== inst_of(64'h8000_1000)) begin
            failures++; $display("FAIL drain_first: got valid=%b pc=%h want 1/80001000", bus.out_valid, bus.out_pc);
        end
    endtask

    task automatic test_fault();
        int en_cycles = 0;
        lat_min = 2; lat_max = 2;
        fault_en = 1'b1;
        fault_addr = 64'h40;
        do_reset();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h40;
        tick();
        bus.redirect_valid = 1'b0;
        repeat (12) tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h40 || bus.out_inst !== 32'h0 || bus.out_page_fault !== 1'b1) begin
            failures++; $display("FAIL fault_entry: got v=%b pc=%h inst=%h pf=%b want 1/40/0/1",
                                 bus.out_valid, bus.out_pc, bus.out_inst, bus.out_page_fault);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL fault_single: got valid=%b want 0", bus.out_valid); end
        repeat (8) begin tick(); if (bus.ic_en) en_cycles++; end
        checks++; if (en_cycles != 0) begin failures++; $display("FAIL fault_halt: got %0d ic_en cycles want 0", en_cycles); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h100;
        tick();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.ic_en !== 1'b1 || bus.ic_req_addr !== 64'h100) begin
            failures++; $display("FAIL fault_resume: got en=%b addr=%h want 1/100", bus.ic_en, bus.ic_req_addr);
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && !bus.out_valid; c++) tick();
        checks++; if (bus.out_pc !== 64'h100 || bus.out_page_fault !== 1'b0 || bus.out_inst !== inst_of(64'h100)) begin
            failures++; $display("FAIL fault_after: got pc=%h pf=%b want 100/0", bus.out_pc, bus.out_page_fault);
        end
        fault_en = 1'b0;
    endtask

    task automatic test_redirect_coincident();
        bit hit = 0;
        lat_min = 1; lat_max = 1;
        do_reset();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && !bus.out_valid; c++) tick();
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            #1;
            if (bus.ic_resp_valid && bus.out_valid) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = 64'h203;
                hit = 1;
            end
        end
        tick();
        bus.redirect_valid = 1'b0;
        checks++; if (!hit) begin failures++; $display("FAIL coinc_setup: got no coincidence want one"); end
        checks++; if (bus.out_valid !== 1'b0 || bus.ic_en !== 1'b1 || bus.ic_req_addr !== 64'h200) begin
            failures++; $display("FAIL coinc_state: got v=%b en=%b addr=%h want 0/1/200", bus.out_valid, bus.ic_en, bus.ic_req_addr);
        end
        for (int c = 0; c < 20 && !bus.out_valid; c++) tick();
        checks++; if (bus.out_pc !== 64'h200) begin failures++; $display("FAIL coinc_first: got pc=%h want 200", bus.out_pc); end
    endtask

    task automatic test_reset_mid_drain();
        lat_min = 4; lat_max = 4;
        do_reset();
        bus.out_ready = 1'b1;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h500;
        tick();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.ic_en !== 1'b1 || bus.ic_req_addr !== 64'h0) begin
            failures++; $display("FAIL mdr_drain: got en=%b addr=%h want 1/0", bus.ic_en, bus.ic_req_addr);
        end
        #1 reset = 1'b1;
        #1;
        checks++; if (bus.ic_en !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_pc !== 64'h0 || bus.out_inst !== 32'h0 || bus.out_page_fault !== 1'b0) begin
            failures++; $display("FAIL mdr_reset_outs: got en=%b v=%b pc=%h inst=%h pf=%b want zeros",
                                 bus.ic_en, bus.out_valid, bus.out_pc, bus.out_inst, bus.out_page_fault);
        end
        repeat (2) tick();
        reset = 1'b0;
        tick();
        checks++; if (bus.ic_en !== 1'b1 || bus.ic_req_addr !== 64'h0) begin
            failures++; $display("FAIL mdr_restart: got en=%b addr=%h want 1/0", bus.ic_en, bus.ic_req_addr);
        end
        for (int c = 0; c < 20 && !bus.out_valid; c++) tick();
        checks++; if (bus.out_pc !== 64'h0) begin failures++; $display("FAIL mdr_first: got pc=%h want 0", bus.out_pc); end
    endtask

    // Reference: decode must see a contiguous pc stream from the last redirect, ending at a fault.
    task automatic test_random();
        logic [63:0] exp_pc = 64'h0;
        logic [63:0] prev_addr = 64'h0;
        logic [63:0] tgt;
        logic [31:0] exp_inst;
        logic        exp_pf;
        logic        prev_en = 1'b0;
        logic        rdy, redir;
        bit          halted = 0;
        int          pops = 0;
        lat_min = 1; lat_max = 4;
        fault_en = 1'b1;
        fault_addr = 64'h80;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (prev_en) begin
                checks++;
                if (!bus.ic_resp_valid && (bus.ic_en !== 1'b1 || bus.ic_req_addr !== prev_addr)) begin
                    failures++; $display("FAIL rand_addr_hold: got en=%b addr=%h want 1/%h", bus.ic_en, bus.ic_req_addr, prev_addr);
                end
            end
            prev_en   = bus.ic_en;
            prev_addr = bus.ic_req_addr;
            rdy   = ($urandom_range(3, 0) != 0);
            redir = ($urandom_range(39, 0) == 0);
            if ($urandom_range(9, 0) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
            else                           tgt = 64'($urandom_range(255, 0));
            bus.out_ready      = rdy;
            bus.redirect_valid = redir;
            bus.redirect_pc    = tgt;
            if (bus.out_valid && rdy && !redir) begin
                exp_pf   = fault_en && (exp_pc == fault_addr);
                exp_inst = exp_pf ? 32'h0 : inst_of(exp_pc);
                checks++;
                if (halted) begin
                    failures++; $display("FAIL rand_after_fault: got pc=%h want no entry", bus.out_pc);
                end else if (bus.out_pc !== exp_pc || bus.out_inst !== exp_inst || bus.out_page_fault !== exp_pf) begin
                    failures++; $display("FAIL rand_pop: got pc=%h inst=%h pf=%b want pc=%h inst=%h pf=%b",
                                         bus.out_pc, bus.out_inst, bus.out_page_fault, exp_pc, exp_inst, exp_pf);
                end
                if (exp_pf) halted = 1;
                else        exp_pc = exp_pc + 64'd4;
                pops++;
            end
            if (redir) begin
                exp_pc = tgt & ~64'h3;
                halted = 0;
            end
        end
        tick();
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b0;
        fault_en           = 1'b0;
        checks++; if (pops < 100) begin failures++; $display("FAIL rand_progress: got %0d pops want >=100", pops); end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_backpressure();
        test_redirect_drain();
        test_fault();
        test_redirect_coincident();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
